skipring_sched: RTL and testbench

//   Sequencer for one skipring instance. Holds a DEPTH-entry table of skip masks and drives the

---
 rtl/skipring_sched.sv | 182 ++++++++++++++++++
 tb/tb_skipring_sched.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/skipring_sched.sv
// skipring_sched: sequencer for one skipring instance.
//   Holds a DEPTH-entry table of skip masks and steps through it, one entry
//   per REVS completed ring revolutions (counted from rising edges of the
//   ring's oB0). Drives the ring's MASK, rSEL, RST and E from mCLK registers.
// Ports:
//   mCLK, nRST        system clock (posedge), synchronous active-low reset
//   WE, WADDR, WDATA  table write port, accepted in every state
//   START, STOP, LOOP sequence control (STOP has priority over START)
//   REVS              revolutions per table entry (0 behaves as 1)
//   B0                ring oB0, asynchronous to mCLK
//   MASK, SEL         ring MASK and rSEL (SEL is constant 1)
//   RRST, RE          ring reset (active-high) and enable
//   BUSY, DONE, IDX   status: ARM/RUN, DONE state, live table entry
module skipring_sched #(
    parameter int LEN   = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int REVW  = 8
) (
    input  logic            mCLK,
    input  logic            nRST,
    input  logic            WE,
    input  logic [AW-1:0]   WADDR,
    input  logic [LEN-1:0]  WDATA,
    input  logic            START,
    input  logic            STOP,
    input  logic            LOOP,
    input  logic [REVW-1:0] REVS,
    input  logic            B0,
    output logic [LEN-1:0]  MASK,
    output logic [LEN-1:0]  SEL,
    output logic            RRST,
    output logic            RE,
    output logic            BUSY,
    output logic            DONE,
    output logic [AW-1:0]   IDX
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [LEN-1:0]    tbl_q [DEPTH];
    logic [LEN-1:0]    tbl_d [DEPTH];
    logic [LEN-1:0]    mask_q, mask_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [REVW-1:0]   revs_q, revs_d;
    logic              loop_q, loop_d;
    logic [REVW-1:0]   revcnt_q, revcnt_d;
    logic [1:0]        armcnt_q, armcnt_d;
    logic              rrst_q, rrst_d;
    logic              re_q, re_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // B0 synchroniser (b0_s1_q, b0_s2_q) and edge-detect delay flop
    logic              b0_s1_q, b0_s2_q, b0_d_q;
    logic              rev_edge;
    logic [REVW-1:0]   revs_eff;
    logic [AW-1:0]     idx_nxt;

    assign rev_edge = b0_s2_q & ~b0_d_q;
    assign revs_eff = (revs_q == '0) ? REVW'(1) : revs_q;
    // DEPTH == 2**AW, so the natural AW-bit wrap yields entry 0 after the last
    assign idx_nxt  = idx_q + 1'b1;

    assign MASK = mask_q;
    assign SEL  = {{(LEN-1){1'b0}}, 1'b1};
    assign RRST = rrst_q;
    assign RE   = re_q;
    assign BUSY = busy_q;
    assign DONE = done_q;
    assign IDX  = idx_q;

    // State and datapath registers
    always_ff @(posedge mCLK) begin
        if (!nRST) begin
            state_q  <= S_IDLE;
            for (int unsigned i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
            mask_q   <= '0;
            idx_q    <= '0;
            revs_q   <= '0;
            loop_q   <= 1'b0;
            revcnt_q <= '0;
            armcnt_q <= '0;
            rrst_q   <= 1'b1;
            re_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            b0_s1_q  <= 1'b0;
            b0_s2_q  <= 1'b0;
            b0_d_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tbl_q    <= tbl_d;
            mask_q   <= mask_d;
            idx_q    <= idx_d;
            revs_q   <= revs_d;
            loop_q   <= loop_d;
            revcnt_q <= revcnt_d;
            armcnt_q <= armcnt_d;
            rrst_q   <= rrst_d;
            re_q     <= re_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            b0_s1_q  <= B0;
            b0_s2_q  <= b0_s1_q;
            b0_d_q   <= b0_s2_q;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        tbl_d    = tbl_q;
        mask_d   = mask_q;
        idx_d    = idx_q;
        revs_d   = revs_q;
        loop_d   = loop_q;
        revcnt_d = revcnt_q;
        armcnt_d = armcnt_q;

        if (WE) tbl_d[WADDR] = WDATA;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (STOP) begin
                    state_d = S_IDLE;
                end else if (START) begin
                    state_d  = S_ARM;
                    mask_d   = tbl_q[0];
                    idx_d    = '0;
                    revs_d   = REVS;
                    loop_d   = LOOP;
                    revcnt_d = '0;
                    armcnt_d = '0;
                end
            end
            S_ARM: begin
                // Held for three edges so RRST=0/RE=1 appear after START edge + 3
                if (STOP) begin
                    state_d = S_IDLE;
                end else if (armcnt_q == 2'd2) begin
                    state_d = S_RUN;
                end else begin
                    armcnt_d = armcnt_q + 2'd1;
                end
            end
            S_RUN: begin
                if (STOP) begin
                    state_d = S_IDLE;
                end else if (rev_edge) begin
                    if (revcnt_q == revs_eff - 1'b1) begin
                        revcnt_d = '0;
                        if (idx_q != AW'(DEPTH - 1) || loop_q) begin
                            idx_d  = idx_nxt;
                            mask_d = tbl_q[idx_nxt];
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        revcnt_d = revcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs follow the next state
    always_comb begin
        rrst_d = (state_d == S_IDLE) || (state_d == S_ARM);
        re_d   = (state_d == S_RUN);
        busy_d = (state_d == S_ARM) || (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

endmodule

// File: tb/tb_skipring_sched.sv
// Directed, table-driven bench for skipring_sched: a vector table covers reset
// release, table writes and the START-to-RUN latency; hand-written sequences
// cover revolution stepping, looping, STOP/START priority, live-entry writes
// and mid-run reset.
module tb_skipring_sched;

    logic        mCLK;
    logic        nRST;
    logic        WE;
    logic [1:0]  WADDR;
    logic [15:0] WDATA;
    logic        START;
    logic        STOP;
    logic        LOOP;
    logic [7:0]  REVS;
    logic        B0;
    logic [15:0] MASK;
    logic [15:0] SEL;
    logic        RRST;
    logic        RE;
    logic        BUSY;
    logic        DONE;
    logic [1:0]  IDX;

    int total = 0;
    int bad   = 0;

    skipring_sched #(.LEN(16), .DEPTH(4), .AW(2), .REVW(8)) dut (
        .mCLK (mCLK),
        .nRST (nRST),
        .WE   (WE),
        .WADDR(WADDR),
        .WDATA(WDATA),
        .START(START),
        .STOP (STOP),
        .LOOP (LOOP),
        .REVS (REVS),
        .B0   (B0),
        .MASK (MASK),
        .SEL  (SEL),
        .RRST (RRST),
        .RE   (RE),
        .BUSY (BUSY),
        .DONE (DONE),
        .IDX  (IDX)
    );

    initial mCLK = 1'b0;
    always #5 mCLK = ~mCLK;

    typedef struct {
        logic        we;
        logic [1:0]  waddr;
        logic [15:0] wdata;
        logic        start;
        logic        stop;
        logic        loop;
        logic [7:0]  revs;
        logic [15:0] emask;
        logic        errst;
        logic        ere;
        logic        ebusy;
        logic        edone;
        logic [1:0]  eidx;
    } vec_t;

    vec_t        vt [8];
    logic [15:0] tblm [4];

    // One posedge, then settle at the following negedge for driving/sampling
    task automatic step();
        @(posedge mCLK);
        @(negedge mCLK);
    endtask

    task automatic chk(input string name, input logic [15:0] m, input logic rr,
                       input logic re, input logic bz, input logic dn, input logic [1:0] ix);
        total++;
        if ({MASK, SEL, RRST, RE, BUSY, DONE, IDX} !== {m, 16'h0001, rr, re, bz, dn, ix}) begin
            bad++;
            $display("FAIL %s: got MASK=%h SEL=%h RRST=%b RE=%b BUSY=%b DONE=%b IDX=%0d, want MASK=%h SEL=0001 RRST=%b RE=%b BUSY=%b DONE=%b IDX=%0d",
                     name, MASK, SEL, RRST, RE, BUSY, DONE, IDX, m, rr, re, bz, dn, ix);
        end
    endtask

    // One ring revolution: B0 low then high, 6 mCLK total; outputs settled after
    task automatic rise();
        B0 = 1'b0;
        repeat (3) step();
        B0 = 1'b1;
        repeat (3) step();
    endtask

    initial begin
        tblm[0] = 16'hCCCC;
        tblm[1] = 16'h00FF;
        tblm[2] = 16'hAAAA;
        tblm[3] = 16'h0001;

        //          we  wa     wdata      st  sp  lp  revs   emask      rr  re  bz  dn  idx
        vt[0] = '{1'b1, 2'd0, 16'hCCCC, 1'b0, 1'b0, 1'b0, 8'd2, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vt[1] = '{1'b1, 2'd1, 16'h00FF, 1'b0, 1'b0, 1'b0, 8'd2, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vt[2] = '{1'b1, 2'd2, 16'hAAAA, 1'b0, 1'b0, 1'b0, 8'd2, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vt[3] = '{1'b1, 2'd3, 16'h0001, 1'b0, 1'b0, 1'b0, 8'd2, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vt[4] = '{1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'd2, 16'hCCCC, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
        vt[5] = '{1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'd2, 16'hCCCC, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
        vt[6] = '{1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'd2, 16'hCCCC, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
        vt[7] = '{1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'd2, 16'hCCCC, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};

        nRST = 1'b0; WE = 1'b0; WADDR = '0; WDATA = '0;
        START = 1'b0; STOP = 1'b0; LOOP = 1'b0; REVS = '0; B0 = 1'b1;
        @(negedge mCLK);

        // Reset
        step();
        step();
        chk("reset", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        nRST = 1'b1;

        // Table writes, START, ARM (START in ARM ignored), RUN after START edge + 3
        for (int i = 0; i < 8; i++) begin
            WE = vt[i].we; WADDR = vt[i].waddr; WDATA = vt[i].wdata;
            START = vt[i].start; STOP = vt[i].stop; LOOP = vt[i].loop; REVS = vt[i].revs;
            step();
            chk($sformatf("vec%0d", i), vt[i].emask, vt[i].errst, vt[i].ere,
                vt[i].ebusy, vt[i].edone, vt[i].eidx);
        end
        WE = 1'b0; START = 1'b0;

        // REVS=2, LOOP=0: entry advances every second rise, DONE after the 8th
        for (int r = 1; r <= 7; r++) begin
            rise();
            chk($sformatf("revs2_rise%0d", r), tblm[r / 2], 1'b0, 1'b1, 1'b1, 1'b0, 2'(r / 2));
        end
        rise();
        chk("revs2_done", 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);

        // START from DONE, LOOP=1, REVS=0 (acts as 1): advance on every rise, wrap
        REVS = 8'd0; LOOP = 1'b1; START = 1'b1;
        step();
        START = 1'b0;
        chk("loop_arm", 16'hCCCC, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        repeat (3) step();
        chk("loop_run", 16'hCCCC, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
        for (int k = 1; k <= 6; k++) begin
            rise();
            chk($sformatf("loop_rise%0d", k), tblm[k % 4], 1'b0, 1'b1, 1'b1, 1'b0, 2'(k % 4));
        end

        // STOP together with START at IDX=2: STOP wins, IDX/MASK hold
        START = 1'b1; STOP = 1'b1;
        step();
        START = 1'b0; STOP = 1'b0;
        chk("stop_start", 16'hAAAA, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
        step();
        chk("stop_idle_hold", 16'hAAAA, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);

        // Write the live entry during RUN with a START pulse: MASK unchanged
        REVS = 8'd1; LOOP = 1'b1; START = 1'b1;
        step();
        START = 1'b0;
        repeat (3) step();
        chk("live_run", 16'hCCCC, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
        WE = 1'b1; WADDR = 2'd0; WDATA = 16'h1234; START = 1'b1;
        step();
        WE = 1'b0; START = 1'b0;
        chk("live_write_hold", 16'hCCCC, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
        tblm[0] = 16'h1234;
        for (int k = 1; k <= 4; k++) begin
            rise();
            chk($sformatf("live_rise%0d", k), tblm[k % 4], 1'b0, 1'b1, 1'b1, 1'b0, 2'(k % 4));
        end

        // STOP alone in RUN
        STOP = 1'b1;
        step();
        STOP = 1'b0;
        chk("stop_run", 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // Reset mid-RUN clears outputs and table
        LOOP = 1'b0; START = 1'b1;
        step();
        START = 1'b0;
        repeat (3) step();
        rise();
        chk("prerst_run", 16'h00FF, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
        nRST = 1'b0;
        step();
        chk("midrun_reset", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        nRST = 1'b1;
        START = 1'b1;
        step();
        START = 1'b0;
        chk("tbl0_cleared", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        repeat (3) step();
        rise();
        chk("tbl1_cleared", 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
